// File: rtl/robertson_mult_seq_if.sv
// robertson_mult_seq_if: start/done operand and product bundle for the Robertson multiplier
interface robertson_mult_seq_if #(parameter int WIDTH = 8);
    logic                 start;
    logic [WIDTH-1:0]     multiplicand;
    logic [WIDTH-1:0]     multiplier;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;
    modport master (output start, multiplicand, multiplier, input busy, done, product);
    modport slave  (input start, multiplicand, multiplier, output busy, done, product);
endinterface

// File: rtl/robertson_mult_seq.sv
// robertson_mult_seq: sequential signed multiplier, Robertson add/shift, one step per cycle
module robertson_mult_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    robertson_mult_seq_if.slave  bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t               state_q, state_d;
    logic [WIDTH-1:0]     a_q, a_d, q_q, q_d, m_q, m_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic                 busy_q, busy_d, done_q, done_d;
    logic [WIDTH:0]       m_ext, addend, sum;
    logic                 last, accept;
    // The final step subtracts M: the multiplier's sign bit carries weight -2^(WIDTH-1)
    assign last   = cnt_q == CW'(WIDTH - 1);
    assign m_ext  = {m_q[WIDTH-1], m_q};
    assign addend = !q_q[0] ? '0 : last ? -m_ext : m_ext;
    assign sum    = {a_q[WIDTH-1], a_q} + addend;
    assign accept = bus.start && state_q != CALC;
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        q_d       = q_q;
        m_d       = m_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        if (accept) begin
            m_d     = bus.multiplicand;
            q_d     = bus.multiplier;
            a_d     = '0;
            cnt_d   = '0;
            state_d = CALC;
        end else if (state_q == CALC) begin
            a_d   = sum[WIDTH:1];
            q_d   = {sum[0], q_q[WIDTH-1:1]};
            cnt_d = cnt_q + 1'b1;
            if (last) begin
                product_d = {sum[WIDTH:1], sum[0], q_q[WIDTH-1:1]};
                state_d   = DONE;
            end
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
        busy_d = state_d == CALC;
        done_d = state_d == DONE;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            a_q       <= '0;
            q_q       <= '0;
            m_q       <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            q_q       <= q_d;
            m_q       <= m_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.product = product_q;
endmodule

// File: tb/tb_robertson_mult_seq.sv
// tb_robertson_mult_seq: directed scoreboard bench for the 8-bit Robertson multiplier
module tb_robertson_mult_seq;
    logic clk = 1'b0;
    logic reset_n = 1'b1;
    int checks = 0;
    int errors = 0;
    logic [15:0] sb[$];
    robertson_mult_seq_if #(.WIDTH(8)) bus ();
    robertson_mult_seq #(.WIDTH(8)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    function automatic logic [15:0] model(input logic [7:0] m, input logic [7:0] q);
        int e;
        e = int'($signed(m)) * int'($signed(q));
        return e[15:0];
    endfunction
    function automatic logic [15:0] pop();
        return sb.size() != 0 ? sb.pop_front() : 16'hxxxx;
    endfunction
    task automatic op(input logic [7:0] m, input logic [7:0] q, input logic [15:0] k, input string tag);
        int n, nb;
        logic both;
        @(negedge clk);
        bus.start = 1'b1;
        bus.multiplicand = m;
        bus.multiplier = q;
        sb.push_back(model(m, q));
        @(posedge clk);
        n = 0; nb = 0; both = 1'b0;
        do begin
            @(negedge clk);
            bus.start = 1'b0;
            n++;
            if (bus.busy) nb++;
            if (bus.busy && bus.done) both = 1'b1;
        end while (!bus.done && n < 40);
        chk({tag, " latency"}, n, 9);
        chk({tag, " busy_cycles"}, nb, 8);
        chk({tag, " busy_done_overlap"}, both, 0);
        chk({tag, " product_sb"}, bus.product, pop());
        chk({tag, " product_const"}, bus.product, k);
        @(negedge clk);
        chk({tag, " done_pulse"}, bus.done, 0);
    endtask
    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end
    initial begin
        int n, nd;
        logic hold;
        logic [15:0] firstp;
        bus.start = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier = '0;
        #1 reset_n = 1'b0;
        #1;
        chk("reset busy", bus.busy, 0);
        chk("reset done", bus.done, 0);
        chk("reset product", bus.product, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        op(8'd7,   8'hFD, 16'hFFEB, "7x-3");
        op(8'h80,  8'h80, 16'h4000, "-128x-128");
        op(8'h7F,  8'h80, 16'hC080, "127x-128");
        op(8'hFF,  8'hFF, 16'h0001, "-1x-1");
        op(8'h00,  8'h5A, 16'h0000, "0x5A");
        // back-to-back: start held high through the DONE cycle
        @(negedge clk);
        bus.start = 1'b1;
        bus.multiplicand = 8'd12;
        bus.multiplier = 8'hF6;
        sb.push_back(model(8'd12, 8'hF6));
        @(posedge clk);
        @(negedge clk);
        bus.multiplicand = 8'h83;
        bus.multiplier = 8'h05;
        n = 1;
        while (!bus.done && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("b2b first latency", n, 9);
        firstp = bus.product;
        chk("b2b first product", firstp, pop());
        chk("b2b first const", firstp, 16'hFF88);
        sb.push_back(model(8'h83, 8'h05));
        @(posedge clk);
        n = 0; hold = 1'b1;
        do begin
            @(negedge clk);
            bus.start = 1'b0;
            n++;
            if (!bus.done && bus.product !== firstp) hold = 1'b0;
        end while (!bus.done && n < 40);
        chk("b2b second spacing", n, 9);
        chk("b2b first held", hold, 1);
        chk("b2b second product", bus.product, pop());
        chk("b2b second const", bus.product, 16'hFD8F);
        // start pulse and operand changes during CALC are ignored
        @(negedge clk);
        bus.start = 1'b1;
        bus.multiplicand = 8'd9;
        bus.multiplier = 8'hF9;
        sb.push_back(model(8'd9, 8'hF9));
        @(posedge clk);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            bus.start = (n == 3);
            if (n == 3) begin
                bus.multiplicand = 8'd100;
                bus.multiplier = 8'd100;
            end
        end while (!bus.done && n < 40);
        chk("ignore latency", n, 9);
        chk("ignore product", bus.product, pop());
        chk("ignore const", bus.product, 16'hFFC1);
        nd = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.done) nd++;
        end
        chk("ignore single done", nd, 0);
        chk("ignore idle busy", bus.busy, 0);
        // asynchronous reset in the middle of an operation
        @(negedge clk);
        bus.start = 1'b1;
        bus.multiplicand = 8'd7;
        bus.multiplier = 8'hFD;
        @(posedge clk);
        repeat (4) @(posedge clk);
        bus.start = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("abort busy", bus.busy, 0);
        chk("abort done", bus.done, 0);
        chk("abort product", bus.product, 0);
        @(negedge clk);
        reset_n = 1'b1;
        nd = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.done || bus.busy) nd++;
        end
        chk("abort no done", nd, 0);
        op(8'd5, 8'd5, 16'h0019, "5x5");
        chk("scoreboard empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
